// File: rtl/bleuart_tx_sched_pkg.sv
// Shared BLEUART transmit-scheduler definitions: frame FSM states and framing constants.
package bleuart_tx_sched_pkg;

    localparam int unsigned ID_W           = 3;
    localparam int unsigned FRAME_OVERHEAD = 3;
    localparam logic [7:0]  SOF_BYTE       = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_ID,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/bleuart_tx_sched_arbiter.sv
// Combinational round-robin grant: first valid requester searching upward from rr_ptr+1.
module bleuart_rr_arbiter
    import bleuart_tx_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx
);

    logic found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!found && req_valid[j] && (j == (32'(rr_ptr) + k) % N_REQ)) begin
                    found       = 1'b1;
                    grant_oh[j] = 1'b1;
                    grant_idx   = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bleuart_tx_sched.sv
// BLE UART transmit scheduler: round-robin packet arbitration, SOF/ID/payload/XOR framing, link-loss abort.
module bleuart_tx_sched
    import bleuart_tx_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned MAX_LEN = 32,
    parameter logic [7:0]  SOF     = SOF_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               link_up,
    output logic               fifo_write,
    output logic [7:0]         fifo_write_data,
    input  logic               fifo_full,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               abort_irq
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      cksum_q, cksum_d;
    logic [7:0]      len_q, len_d;
    logic            trunc_q, trunc_d;

    logic [N_REQ-1:0] arb_oh;
    logic [ID_W-1:0]  arb_idx;
    logic [N_REQ-1:0] g_oh;
    logic [7:0]       g_data;
    logic             g_valid, g_last;
    logic             can_wr, framing;

    bleuart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    always_comb begin
        g_oh    = '0;
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_oh[i] = 1'b1;
                g_data  = req_data[8*i +: 8];
                g_valid = req_valid[i];
                g_last  = req_last[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        cksum_d         = cksum_q;
        len_d           = len_q;
        trunc_d         = trunc_q;
        fifo_write      = 1'b0;
        fifo_write_data = '0;
        req_ready       = '0;
        abort_irq       = 1'b0;
        can_wr          = link_up && !fifo_full;
        framing         = state_q inside {ST_SOF, ST_ID, ST_PAYLOAD, ST_CKSUM};

        // Link loss overrides any write; only a completed packet may skip the drain.
        if (framing && !link_up) begin
            abort_irq = 1'b1;
            state_d   = (state_q == ST_CKSUM && !trunc_q) ? ST_IDLE : ST_DRAIN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (link_up && (|arb_oh)) begin
                        grant_d  = arb_idx;
                        rr_ptr_d = arb_idx;
                        cksum_d  = '0;
                        len_d    = '0;
                        trunc_d  = 1'b0;
                        state_d  = ST_SOF;
                    end
                end
                ST_SOF: begin
                    fifo_write      = can_wr;
                    fifo_write_data = SOF;
                    if (can_wr) state_d = ST_ID;
                end
                ST_ID: begin
                    fifo_write      = can_wr;
                    fifo_write_data = {{(8-ID_W){1'b0}}, grant_q};
                    if (can_wr) begin
                        cksum_d = {{(8-ID_W){1'b0}}, grant_q};
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    req_ready       = g_oh & {N_REQ{can_wr}};
                    fifo_write      = can_wr && g_valid;
                    fifo_write_data = g_data;
                    if (fifo_write) begin
                        cksum_d = cksum_q ^ g_data;
                        len_d   = len_q + 8'd1;
                        if (g_last) begin
                            state_d = ST_CKSUM;
                        end else if (len_d == 8'(MAX_LEN)) begin
                            trunc_d = 1'b1;
                            state_d = ST_CKSUM;
                        end
                    end
                end
                ST_CKSUM: begin
                    fifo_write      = can_wr;
                    fifo_write_data = cksum_q;
                    if (can_wr) begin
                        abort_irq = trunc_q;
                        state_d   = trunc_q ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    req_ready = g_oh;
                    if (g_valid && g_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(N_REQ - 1);
            cksum_q  <= '0;
            len_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cksum_q  <= cksum_d;
            len_q    <= len_d;
            trunc_q  <= trunc_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule
